// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: M-extension Funct3 codes, the MULDIV Funct7 and the muldiv FSM encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Magnitude shift-add multiply / restoring divide with final sign fix and result register.
// Latency: load, 32 step strobes, then fix writes Result (fast strobe writes it directly).
// Backpressure: none; strictly driven by the load/step/fix/fast strobes from the FSM.
// Ports: clk_i, rst_i; load_i/step_i/fix_i/fast_i strobes; funct3_i, operand_a_i,
//        operand_b_i (sampled on load_i); fast_result_i (sampled on fast_i); result_o.
module muldiv_datapath
    import riscv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            fix_i,
    input  logic            fast_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic [XLEN-1:0] fast_result_i,
    output logic [XLEN-1:0] result_o
);

    logic [63:0]     prod_q, prod_d;     // {hi, lo} product or {remainder, quotient}
    logic [XLEN-1:0] mcand_q, mcand_d;   // multiplicand or divisor magnitude
    logic [2:0]      f3_q, f3_d;
    logic            sgn_a_q, sgn_a_d;
    logic            sgn_b_q, sgn_b_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            sgn_a, sgn_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [32:0]     add_sum, rem_sh, sub_diff;
    logic [63:0]     prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix, fix_word;

    // Which operands are treated as signed for the incoming op.
    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        case (funct3_i)
            F3_MULH, F3_DIV, F3_REM: begin
                sgn_a = operand_a_i[XLEN-1];
                sgn_b = operand_b_i[XLEN-1];
            end
            F3_MULHSU: sgn_a = operand_a_i[XLEN-1];
            default: ;
        endcase
    end

    assign mag_a = sgn_a ? (~operand_a_i + 1'b1) : operand_a_i;
    assign mag_b = sgn_b ? (~operand_b_i + 1'b1) : operand_b_i;

    // Multiply: 33-bit add keeps the carry, which is shifted back into bit 63.
    assign add_sum  = {1'b0, prod_q[63:32]} + {1'b0, mcand_q};
    // Divide: remainder after the left shift can be 33 bits wide, so trial-subtract on 33.
    assign rem_sh   = prod_q[63:31];
    assign sub_diff = rem_sh - {1'b0, mcand_q};

    always_comb begin
        prod_d  = prod_q;
        mcand_d = mcand_q;
        f3_d    = f3_q;
        sgn_a_d = sgn_a_q;
        sgn_b_d = sgn_b_q;
        if (load_i) begin
            f3_d    = funct3_i;
            sgn_a_d = sgn_a;
            sgn_b_d = sgn_b;
            if (funct3_i[2]) begin
                prod_d  = {32'd0, mag_a};   // dividend shifts out of the low half
                mcand_d = mag_b;
            end else begin
                prod_d  = {32'd0, mag_b};   // multiplier consumed from the LSB
                mcand_d = mag_a;
            end
        end else if (step_i) begin
            if (f3_q[2]) begin
                if (!sub_diff[32]) begin
                    prod_d = {sub_diff[31:0], prod_q[30:0], 1'b1};
                end else begin
                    prod_d = {rem_sh[31:0], prod_q[30:0], 1'b0};
                end
            end else begin
                if (prod_q[0]) begin
                    prod_d = {add_sum, prod_q[31:1]};
                end else begin
                    prod_d = {1'b0, prod_q[63:1]};
                end
            end
        end
    end

    // Sign fix: for MULHSU sgn_b_q is always 0, so the XOR reduces to sign A.
    assign prod_fix = (sgn_a_q ^ sgn_b_q) ? (~prod_q + 64'd1) : prod_q;
    assign quo_fix  = (sgn_a_q ^ sgn_b_q) ? (~prod_q[31:0] + 1'b1) : prod_q[31:0];
    assign rem_fix  = sgn_a_q ? (~prod_q[63:32] + 1'b1) : prod_q[63:32];

    always_comb begin
        fix_word = prod_fix[63:32];
        case (f3_q)
            F3_MUL:           fix_word = prod_fix[31:0];
            F3_DIV, F3_DIVU:  fix_word = quo_fix;
            F3_REM, F3_REMU:  fix_word = rem_fix;
            default:          fix_word = prod_fix[63:32];
        endcase
    end

    always_comb begin
        result_d = result_q;
        if (fast_i) begin
            result_d = fast_result_i;
        end else if (fix_i) begin
            result_d = fix_word;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prod_q   <= '0;
            mcand_q  <= '0;
            f3_q     <= '0;
            sgn_a_q  <= 1'b0;
            sgn_b_q  <= 1'b0;
            result_q <= '0;
        end else begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            f3_q     <= f3_d;
            sgn_a_q  <= sgn_a_d;
            sgn_b_q  <= sgn_b_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: FSM, iteration counter, start/busy/done handshake, fast-path detect.
// Latency: 33 edges after accept (Done the cycle after), 1 cycle for degenerate divides.
// Backpressure: Busy_o stalls the pipeline; Start_i is only taken in IDLE/DONE and never queued.
// Ports: clk_i, rst_i; Start_i, Funct3_i, OperandA_i, OperandB_i, Flush_i in;
//        Busy_o, Done_o (one-cycle pulse), Result_o (held until next Done) out.
module muldiv_unit
    import riscv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            Start_i,
    input  logic [2:0]      Funct3_i,
    input  logic [XLEN-1:0] OperandA_i,
    input  logic [XLEN-1:0] OperandB_i,
    input  logic            Flush_i,
    output logic            Busy_o,
    output logic            Done_o,
    output logic [XLEN-1:0] Result_o
);

    muldiv_state_t   state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;

    logic            accept;
    logic            fast_hit;
    logic [XLEN-1:0] fast_res;
    logic            load, step, fix, fast;

    assign accept = Start_i && !Flush_i && (state_q == ST_IDLE || state_q == ST_DONE);

    // Divide by zero and signed overflow have architecturally fixed answers.
    always_comb begin
        fast_hit = 1'b0;
        fast_res = '0;
        if (Funct3_i[2]) begin
            if (OperandB_i == '0) begin
                fast_hit = 1'b1;
                fast_res = Funct3_i[1] ? OperandA_i : '1;
            end else if (!Funct3_i[0] && OperandA_i == 32'h8000_0000 &&
                         OperandB_i == 32'hFFFF_FFFF) begin
                fast_hit = 1'b1;
                fast_res = Funct3_i[1] ? 32'h0000_0000 : 32'h8000_0000;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        fast    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    cnt_d = '0;
                    if (fast_hit) begin
                        fast    = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        load    = 1'b1;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (Flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (Flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    fix     = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Busy_o = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign Done_o = (state_q == ST_DONE);

    muldiv_datapath u_datapath (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .load_i        (load),
        .step_i        (step),
        .fix_i         (fix),
        .fast_i        (fast),
        .funct3_i      (Funct3_i),
        .operand_a_i   (OperandA_i),
        .operand_b_i   (OperandB_i),
        .fast_result_i (fast_res),
        .result_o      (Result_o)
    );

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU in the execute stage. Decode issues it any OP instruction with Funct7 = 0000001. It runs a start/busy/done handshake so the pipeline controller can stall while a result is computed over 33 cycles. Degenerate divides take a one-cycle fast path. Shift-add multiply and restoring divide run on operand magnitudes, with a final sign-fix cycle.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- Start_i  in  1  issue request; sampled only when the unit can accept.
- Funct3_i  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- OperandA_i  in  XLEN  rs1 value (multiplicand / dividend).
- OperandB_i  in  XLEN  rs2 value (multiplier / divisor).
- Flush_i  in  1  abort the in-flight operation; no Done is produced.
- Busy_o  out  1  operation in progress; pipeline must stall.
- Done_o  out  1  one-cycle pulse; Result_o is valid this cycle.
- Result_o  out  XLEN  result of the last completed operation; held until the next Done.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- Accept: Start_i=1 in IDLE or DONE and Flush_i=0.
  - Latch Funct3 and operand signs.
  - Load magnitudes. Signed handling: MULH both operands, MULHSU A only, DIV/REM both.
  - Clear the 5-bit iteration counter and enter CALC.
- Fast path, decided at accept:
  - B=0 on DIV/DIVU: quotient 0xFFFFFFFF.
  - B=0 on REM/REMU: remainder = A.
  - DIV with A=0x80000000 and B=0xFFFFFFFF: quotient 0x80000000.
  - REM with A=0x80000000 and B=0xFFFFFFFF: remainder 0.
  - Fast-path cases go directly to DONE.
- CALC, multiply: 64-bit product register. If the multiplier LSB is 1, add the multiplicand into the upper half with a 33-bit carry. Then shift right 1.
- CALC, divide: 64-bit {remainder, quotient} register, shifted left 1. Trial subtract divisor from the upper 33 bits; if non-negative, commit and set quotient bit 0.
- Counter increments once per CALC cycle; counter = 31 moves the FSM to FIX.
- FIX:
  - Negate the 64-bit product if the latched signs differ (MULHSU: sign A only).
  - Negate the quotient if sign A ^ sign B; negate the remainder if sign A.
  - Select the output word: MUL low, MULH* high, DIV*/REM* per Funct3.
  - Register it into Result_o and move to DONE.
- DONE: Done_o=1. Next state is CALC or DONE if a new Start is accepted, else IDLE.
- Start_i in CALC or FIX is ignored; it is not queued.
- Flush_i in CALC, FIX or DONE goes to IDLE next edge. No Done; Result_o is unchanged.
- Flush_i together with Start_i: the flush wins and nothing is accepted.
- All arithmetic is modulo 2^64 internally. Overflow of MUL low word is silently truncated.

## Timing
- Reset values: state IDLE, Busy_o=0, Done_o=0, Result_o=0, counter 0, datapath registers 0.
- Reset mid-operation returns the unit to IDLE immediately, with no Done.
- Acceptance edge is E0. CALC covers E1..E32, FIX is E33, and Done_o is high in the cycle after E33.
- Normal latency: 33 cycles after the accept edge.
- Fast path: Done_o is high in the cycle after E0, i.e. latency 1.
- Busy_o is combinational from state: 1 in CALC and FIX, 0 in IDLE and DONE.
- Result_o changes only on the edge that enters DONE.
- Back-to-back operations: a Start accepted in the DONE cycle gives one Done every 34 cycles.

## Structure
- Shared riscv_pkg holds:
  - Funct3 M-extension constants (MUL..REMU).
  - FUNCT7_MULDIV = 7'b0000001.
  - muldiv_state_t encoding.
- muldiv_unit holds the FSM, counter, handshake and fast-path detect.
- Sub-module muldiv_datapath holds the 64-bit shift register, the 33-bit add/subtract and the FIX negation/select. It takes control strobes load/step/fix from the FSM.

## Test plan
- MUL, A=7, B=0xFFFFFFFD, after 33 cycles -> Result_o=0xFFFFFFEB, Done_o pulses once, Busy_o high for 33 cycles.
- MULH and MULHU, A=B=0x80000000 -> 0x40000000 and 0x40000000. MULHSU with the same operands -> 0xC0000000.
- DIV, A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF. DIVU, A=100, B=7 -> 14.
- Fast path:
  - DIVU, A=5, B=0 -> 0xFFFFFFFF with Done one cycle after accept.
  - REM, A=5, B=0 -> 5.
  - DIV, A=0x80000000, B=0xFFFFFFFF -> 0x80000000.
- Flush_i at CALC cycle 10 -> Busy_o=0 next cycle, no Done_o, Result_o keeps its old value. A new Start then completes normally.
- rst_i asserted mid-CALC -> all outputs 0 immediately. Start_i during CALC is ignored, and Start_i in the DONE cycle gives a second Done 34 cycles after the first.
